fetch_aligner: RTL

- Parametrised, registered fetch-group aligner between decoder and issue queues.
- Takes FETCH_WIDTH decoded instructions plus group PC. Finds the first branch, masks wrong-path slots after its delay slot, and reports branch address/target back to fetch.
- Carries a pending delay slot across group boundaries when the branch is the last slot.
- Supports stall and flush.

---
 rtl/fetch_aligner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_aligner.sv
// Registered fetch-group aligner: finds the first branch, masks slots past its delay slot,
// and carries a pending delay slot across groups. Optional branch counter: FETCH_ALIGNER_PERF_EN.
module fetch_aligner #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSN_WIDTH    = 99,
  parameter int FETCH_WIDTH   = 4,
  parameter int INSN_BYTES    = 4,
  parameter int BRANCH_BIT    = 9,
  parameter int TARGET_LSB    = 10
) (
  input  logic                              i_Clk,
  input  logic                              i_Reset_n,
  input  logic                              i_Stall,
  input  logic                              i_Flush,
  input  logic                              i_valid,
  input  logic [ADDRESS_WIDTH-1:0]          i_pc,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] i_isn,
`ifdef FETCH_ALIGNER_PERF_EN
  input  logic                              i_count_clr,
  output logic [15:0]                       o_branch_count,
`endif
  output logic [FETCH_WIDTH-1:0]            o_valid,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] o_isn,
  output logic [ADDRESS_WIDTH-1:0]          o_pc,
  output logic                              o_isbranch,
  output logic [ADDRESS_WIDTH-1:0]          o_branch_addr,
  output logic [ADDRESS_WIDTH-1:0]          o_branch_target
);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_DS_PEND = 1'b1;

  logic [0:0]                        r_state;
  logic [FETCH_WIDTH-1:0]            r_valid;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0] r_isn;
  logic [ADDRESS_WIDTH-1:0]          r_pc;
  logic                              r_isbranch;
  logic [ADDRESS_WIDTH-1:0]          r_branch_addr;
  logic [ADDRESS_WIDTH-1:0]          r_branch_target;

  logic                              w_found;
  logic                              w_prev;
  logic                              w_last_slot;
  logic [FETCH_WIDTH-1:0]            w_mask;
  logic [ADDRESS_WIDTH-1:0]          w_addr;
  logic [ADDRESS_WIDTH-1:0]          w_target;
  logic                              w_accept;
  logic                              w_branch_load;

  // Single priority scan: a slot stays valid until the first branch, plus the one slot after it.
  always_comb begin
    w_found     = 1'b0;
    w_prev      = 1'b0;
    w_last_slot = 1'b0;
    w_mask      = '0;
    w_addr      = '0;
    w_target    = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      w_mask[i] = !w_found || w_prev;
      w_prev    = 1'b0;
      if (!w_found && i_isn[i*INSN_WIDTH+BRANCH_BIT]) begin
        w_found     = 1'b1;
        w_prev      = 1'b1;
        w_last_slot = (i == FETCH_WIDTH - 1);
        w_addr      = i_pc + ADDRESS_WIDTH'(i * INSN_BYTES);
        w_target    = i_isn[i*INSN_WIDTH+TARGET_LSB +: ADDRESS_WIDTH];
      end
    end
  end

  assign w_accept      = i_valid && !i_Stall && !i_Flush;
  assign w_branch_load = w_accept && (r_state == ST_NORMAL) && w_found;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state         <= ST_NORMAL;
      r_valid         <= '0;
      r_isn           <= '0;
      r_pc            <= '0;
      r_isbranch      <= 1'b0;
      r_branch_addr   <= '0;
      r_branch_target <= '0;
    end else if (i_Flush) begin
      r_valid    <= '0;
      r_isbranch <= 1'b0;
      r_state    <= ST_NORMAL;
    end else if (i_Stall) begin
      r_state <= r_state;
    end else if (!i_valid) begin
      r_valid    <= '0;
      r_isbranch <= 1'b0;
    end else begin
      r_isn <= i_isn;
      r_pc  <= i_pc;
      if (r_state == ST_DS_PEND) begin
        // Only the carried-over delay slot is real; any flags in this group are ignored.
        r_valid    <= FETCH_WIDTH'(1);
        r_isbranch <= 1'b0;
        r_state    <= ST_NORMAL;
      end else begin
        r_valid    <= w_mask;
        r_isbranch <= w_found;
        if (w_found) begin
          r_branch_addr   <= w_addr;
          r_branch_target <= w_target;
        end
        r_state <= (w_found && w_last_slot) ? ST_DS_PEND : ST_NORMAL;
      end
    end
  end

`ifdef FETCH_ALIGNER_PERF_EN
  logic [15:0] r_branch_count;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_branch_count <= '0;
    end else if (i_count_clr) begin
      r_branch_count <= '0;
    end else if (w_branch_load && (r_branch_count != '1)) begin
      r_branch_count <= r_branch_count + 16'd1;
    end
  end

  assign o_branch_count = r_branch_count;
`endif

  assign o_valid         = r_valid;
  assign o_isn           = r_isn;
  assign o_pc            = r_pc;
  assign o_isbranch      = r_isbranch;
  assign o_branch_addr   = r_branch_addr;
  assign o_branch_target = r_branch_target;

endmodule
